// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block constants, byte order and input FSM encoding
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = AES_BLOCK_BYTES * 8;

  // First byte on the wire is the most significant byte of the block (shared with the output serializer)
  localparam bit BYTE_MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2
  } in_state_t;

endpackage

// File: rtl/byte_deserializer.sv
// rtl/byte_deserializer.sv - byte-serial to block shift register with byte count and block tag
module byte_deserializer
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [7:0]        byte_in,
  input  logic              byte_en,
  input  logic              tag_in,
  output logic [NBYTES*8-1:0] assembled,
  output logic              tag,
  output logic              done
);

  localparam int W = NBYTES * 8;

  logic [W-1:0]     shift_reg;
  logic [CNT_W-1:0] count;
  logic             tag_q;
  logic             first;
  logic             last;

  assign first = (count == '0);
  assign last  = (count == CNT_W'(NBYTES - 1));

  // assembled includes the byte on the bus, so completion is seen on the same edge it is accepted
  assign assembled = BYTE_MSB_FIRST ? {shift_reg[W-9:0], byte_in} : {byte_in, shift_reg[W-1:8]};
  assign tag       = first ? tag_in : tag_q;
  assign done      = byte_en && last;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      shift_reg <= '0;
      count     <= '0;
      tag_q     <= 1'b0;
    end else if (byte_en) begin
      shift_reg <= assembled;
      count     <= last ? '0 : count + CNT_W'(1);
      if (first) tag_q <= tag_in;
    end
  end

endmodule

// File: rtl/input_interface.sv
// rtl/input_interface.sv - AES byte-serial front end: key/plaintext assembly and engine start handshake
module input_interface
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  input  logic                load_key,
  input  logic                engine_ready,
  output logic                in_ready,
  output logic [NBYTES*8-1:0] plaintext,
  output logic [NBYTES*8-1:0] key,
  output logic                key_valid,
  output logic                start,
  output logic                err
);

  localparam int W = NBYTES * 8;

  in_state_t    state, next_state;
  logic [W-1:0] assembled;
  logic         blk_is_key;
  logic         blk_done;
  logic         accept;
  logic         pt_take;
  logic         in_ready_d, start_d, err_d;

  assign accept  = data_valid && in_ready;
  assign pt_take = blk_done && !blk_is_key && key_valid;

  byte_deserializer #(.NBYTES(NBYTES), .CNT_W(CNT_W)) u_deser (
    .clk      (clk),
    .rst_     (rst_),
    .byte_in  (data_in),
    .byte_en  (accept),
    .tag_in   (load_key),
    .assembled(assembled),
    .tag      (blk_is_key),
    .done     (blk_done)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_FILL;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FILL:  if (pt_take) next_state = ST_HOLD;
      ST_HOLD:  if (engine_ready) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_FILL;
      default:  next_state = ST_FILL;
    endcase
  end

  // Output values for the next cycle; registered below so every output comes from a flop
  always_comb begin
    in_ready_d = (next_state == ST_FILL);
    start_d    = (state == ST_ISSUE);
    err_d      = blk_done && !blk_is_key && !key_valid;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      in_ready  <= 1'b0;
      start     <= 1'b0;
      err       <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      plaintext <= '0;
    end else begin
      in_ready <= in_ready_d;
      start    <= start_d;
      err      <= err_d;
      if (blk_done && blk_is_key) begin
        key       <= assembled;
        key_valid <= 1'b1;
      end
      if (pt_take) plaintext <= assembled;
    end
  end

endmodule
